fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage feeding MemControler's IF port and the IF/ID boundary.
//  - Keeps the PC and issues reads on if_mc_en/if_mc_addr.
//  - Captures mc_if_data into a small prefetch FIFO, tagged with its PC.
//  - Yields to the MEM port whenever mem_mc_en is high, and handles redirects (branch/jump).
// PARAMETERS
//  ADDR_W      18   halfword address width (matches mc_ram_addr)
//  DATA_W      32   instruction width (two 16-bit RAM halves)
//  MC_LAT      2    cycles from if_mc_en sampled to mc_if_data valid (>=1)
//  FIFO_DEPTH  2    prefetch entries (power of 2, >=2)
//  RESET_PC    0    PC after reset (even)
// PORTS
//  clock           in   1       clock, rising edge
//  reset           in   1       asynchronous, active-low
//  if_mc_en        out  1       fetch request to MemControler
//  if_mc_addr      out  ADDR_W  fetch halfword address (bit0 always 0)
//  mc_if_data      in   DATA_W  fetched instruction
//  mem_mc_en       in   1       MEM stage owns memory this cycle (preempts fetch)
//  redirect_en     in   1       flush and restart at redirect_addr
//  redirect_addr   in   ADDR_W  new PC (bit0 ignored, forced 0)
//  if_id_valid     out  1       FIFO head valid
//  if_id_instr     out  DATA_W  FIFO head instruction
//  if_id_pc        out  ADDR_W  FIFO head PC
//  id_if_ready     in   1       decode accepts head this cycle
// BEHAVIOUR
//  - Reset (async, low): PC=RESET_PC; state=IDLE; FIFO empty; lat_cnt=0.
//    Outputs on reset: if_mc_en=0, if_mc_addr=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc=0.
//  - FSM
//    - IDLE -> REQ when count<FIFO_DEPTH, redirect_en=0 and mem_mc_en=0.
//    - REQ: if_mc_en=1, if_mc_addr=PC, lat_cnt=MC_LAT-1.
//      - Goes to WAIT, or directly to CAPTURE when MC_LAT=1.
//    - WAIT: if_mc_en held 1 with stable addr.
//      - lat_cnt decrements each cycle; at 0 go to CAPTURE.
//    - CAPTURE: push {PC, mc_if_data}; PC+=2.
//      - Then REQ if there is room, else IDLE (back-to-back fetch, no bubble).
//  - Preemption: mem_mc_en=1 in any REQ/WAIT cycle aborts the transaction.
//    - State -> IDLE, PC unchanged, if_mc_en=0 that cycle.
//    - Re-issue on the first cycle with mem_mc_en=0.
//  - Redirect: redirect_en=1 has top priority over everything.
//    - Same edge: FIFO flushed, in-flight fetch dropped (no push), PC=redirect_addr&~1, state=IDLE.
//    - if_id_valid=0 in the next cycle.
//  - FIFO: push only in CAPTURE. Pop when if_id_valid & id_if_ready.
//    - Push and pop in the same cycle: count unchanged.
//    - Push when full never happens: issue is gated on count<FIFO_DEPTH (a pop in CAPTURE frees a slot).
//    - Pop when empty is ignored.
//  - Head is registered; if_id_instr/pc are stable while valid & !ready.
//  - PC wraps modulo 2^ADDR_W (0x3FFFE+2 -> 0x00000).
//  - Throughput with no stalls: one instruction per MC_LAT+1 cycles after the first fetch.
// STRUCTURE
//  - pinca_defs.vh: FSM state encodings (IDLE/REQ/WAIT/CAPTURE), PC_STEP=2, ADDR_W/DATA_W defaults.
//  - Sub-module fetch_fifo: synchronous FIFO with flush, DATA_W+ADDR_W wide, FIFO_DEPTH deep.
//  - fetch_unit top: PC, FSM, latency counter.
// TESTING
//  1. Reset low mid-WAIT -> if_mc_en=0, if_id_valid=0, PC=0 immediately.
//     After release, first fetch addr=0x00000.
//  2. Free run, MC model returns addr*3, MC_LAT=2, id_if_ready=1.
//     -> if_id_pc sequence 0,2,4,6; instrs 0,6,12,18; one push every 3 cycles.
//  3. mem_mc_en=1 for 4 cycles during WAIT of PC=4.
//     -> if_mc_en drops, refetch of 0x00004 after release; no duplicate or skipped PC.
//  4. id_if_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries (pc 0,2) held stable, if_mc_en=0.
//     Ready=1 -> pops in order, fetch resumes at 4.
//  5. redirect_en with redirect_addr=0x00101 on the same edge as CAPTURE.
//     -> data dropped, FIFO empty, next if_mc_addr=0x00100.
//  6. PC=0x3FFFE fetched -> next if_mc_addr=0x00000 (wrap).

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StCapture
    } fetch_state_e;

    localparam int unsigned PC_STEP        = 2;
    localparam int unsigned ADDR_W_DEFAULT = 18;
    localparam int unsigned DATA_W_DEFAULT = 32;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO with synchronous flush; head entry is read straight from registered storage.
module fetch_unit_fifo #(
    parameter int unsigned WIDTH = 50,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    assign do_pop = pop && (count_q != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign valid     = (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, request/wait/capture FSM towards the memory controller, prefetch FIFO.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned MC_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              if_mc_en,
    output logic [ADDR_W-1:0] if_mc_addr,
    input  logic [DATA_W-1:0] mc_if_data,
    input  logic              mem_mc_en,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    input  logic              id_if_ready
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LAT_W   = $clog2(MC_LAT + 1);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [LAT_W-1:0]  lat_cnt_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_valid;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     count_after_push;
    logic               room_idle;
    logic               room_after_capture;

    assign fifo_push = (state_q == StCapture) && !redirect_en;
    assign fifo_pop  = fifo_valid && id_if_ready;

    // A pop in the capture cycle frees the slot the push would otherwise fill.
    assign count_after_push   = {1'b0, fifo_count} + (CNT_W + 1)'(1) - (CNT_W + 1)'(fifo_pop);
    assign room_after_capture = count_after_push < (CNT_W + 1)'(FIFO_DEPTH);
    assign room_idle          = fifo_count < CNT_W'(FIFO_DEPTH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pc_q      <= ADDR_W'(RESET_PC);
            lat_cnt_q <= '0;
        end else if (redirect_en) begin
            state_q   <= StIdle;
            pc_q      <= redirect_addr & ~(ADDR_W'(1));
            lat_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (room_idle && !mem_mc_en) begin
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (mem_mc_en) begin
                        state_q <= StIdle;
                    end else begin
                        lat_cnt_q <= LAT_W'(MC_LAT - 1);
                        state_q   <= (MC_LAT == 1) ? StCapture : StWait;
                    end
                end
                StWait: begin
                    if (mem_mc_en) begin
                        state_q <= StIdle;
                    end else if (lat_cnt_q <= LAT_W'(1)) begin
                        lat_cnt_q <= '0;
                        state_q   <= StCapture;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                    end
                end
                StCapture: begin
                    pc_q    <= pc_q + ADDR_W'(PC_STEP);
                    state_q <= room_after_capture ? StReq : StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The MEM port wins the memory in the very cycle it asks for it.
    assign if_mc_en   = ((state_q == StReq) || (state_q == StWait)) && !mem_mc_en;
    assign if_mc_addr = pc_q;

    fetch_unit_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_en),
        .push      (fifo_push),
        .push_data ({pc_q, mc_if_data}),
        .pop       (fifo_pop),
        .valid     (fifo_valid),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign if_id_valid = fifo_valid;
    assign if_id_pc    = fifo_head[ENTRY_W-1:DATA_W];
    assign if_id_instr = fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic checked against a sequential-PC model.
module tb_fetch_unit;

    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MC_LAT     = 2;
    localparam int unsigned FIFO_DEPTH = 2;

    logic              clock;
    logic              reset;
    logic              if_mc_en;
    logic [ADDR_W-1:0] if_mc_addr;
    logic [DATA_W-1:0] mc_if_data;
    logic              mem_mc_en;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_addr;
    logic              if_id_valid;
    logic [DATA_W-1:0] if_id_instr;
    logic [ADDR_W-1:0] if_id_pc;
    logic              id_if_ready;

    fetch_unit #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MC_LAT     (MC_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .if_mc_en      (if_mc_en),
        .if_mc_addr    (if_mc_addr),
        .mc_if_data    (mc_if_data),
        .mem_mc_en     (mem_mc_en),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .id_if_ready   (id_if_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_total = 0;

    always @(posedge clock) cyc++;

    function automatic logic [DATA_W-1:0] instr_of(input logic [ADDR_W-1:0] pc);
        return DATA_W'(pc) * DATA_W'(3);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event never seen within bound (cycle %0d)", name, cyc);
    endtask

    // Memory controller: data appears MC_LAT edges after the request was sampled.
    logic [ADDR_W:0] mc_pipe [MC_LAT];
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(MC_LAT); i++) mc_pipe[i] <= '0;
        end else begin
            mc_pipe[0] <= {if_mc_en, if_mc_addr};
            for (int i = 1; i < int'(MC_LAT); i++) mc_pipe[i] <= mc_pipe[i-1];
        end
    end
    assign mc_if_data = mc_pipe[MC_LAT-1][ADDR_W] ? instr_of(mc_pipe[MC_LAT-1][ADDR_W-1:0])
                                                  : 32'hDEAD_BEEF;

    // Reference: after reset/redirect the decoder sees pc, pc+2, ... with data pc*3.
    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } exp_t;
    exp_t              exp_q[$];
    logic [ADDR_W-1:0] model_pc;

    task automatic topup();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc    = model_pc;
            e.instr = instr_of(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + ADDR_W'(2);
        end
    endtask

    task automatic model_restart(input logic [ADDR_W-1:0] a);
        exp_q.delete();
        model_pc = a & ~(ADDR_W'(1));
        topup();
    endtask

    // Monitor
    logic              hold_prev  = 1'b0;
    logic              redir_prev = 1'b0;
    logic [ADDR_W-1:0] hold_pc;
    logic [DATA_W-1:0] hold_instr;

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            hold_prev  = 1'b0;
            redir_prev = 1'b0;
        end else begin
            if (mem_mc_en) check("yield_to_mem", 64'(if_mc_en), 64'd0);
            if (if_mc_en) check("addr_even", 64'(if_mc_addr[0]), 64'd0);
            if (redir_prev) check("valid_after_redirect", 64'(if_id_valid), 64'd0);
            if (hold_prev) begin
                check("hold_valid", 64'(if_id_valid), 64'd1);
                check("hold_pc", 64'(if_id_pc), 64'(hold_pc));
                check("hold_instr", 64'(if_id_instr), 64'(hold_instr));
            end
            if (if_id_valid && id_if_ready) begin
                topup();
                e = exp_q.pop_front();
                check("sb_pc", 64'(if_id_pc), 64'(e.pc));
                check("sb_instr", 64'(if_id_instr), 64'(e.instr));
                hs_total++;
            end
            hold_prev  = if_id_valid && !id_if_ready && !redirect_en;
            hold_pc    = if_id_pc;
            hold_instr = if_id_instr;
            redir_prev = redirect_en;
        end
    end

    task automatic wait_req(input logic prev0, output logic ok, output logic [ADDR_W-1:0] addr);
        logic prev;
        prev = prev0;
        ok   = 1'b0;
        addr = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (if_mc_en && !prev) begin
                ok   = 1'b1;
                addr = if_mc_addr;
                break;
            end
            prev = if_mc_en;
        end
    endtask

    task automatic wait_valid(output logic ok, output logic [ADDR_W-1:0] pc,
                              output logic [DATA_W-1:0] instr, output int at);
        ok = 1'b0;
        pc = '0;
        instr = '0;
        at = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (if_id_valid && id_if_ready) begin
                ok = 1'b1;
                pc = if_id_pc;
                instr = if_id_instr;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic do_redirect(input logic [ADDR_W-1:0] a);
        @(posedge clock);
        #1;
        redirect_en   = 1'b1;
        redirect_addr = a;
        id_if_ready   = 1'b0;
        model_restart(a);
        @(posedge clock);
        #1;
        redirect_en = 1'b0;
        id_if_ready = 1'b1;
    endtask

    initial begin
        logic              ok;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] ins;
        int                at;
        int                prev_at;

        reset = 1'b0;
        mem_mc_en = 1'b0;
        redirect_en = 1'b0;
        redirect_addr = '0;
        id_if_ready = 1'b0;
        model_restart('0);
        #1;
        check("rst_mc_en", 64'(if_mc_en), 64'd0);
        check("rst_mc_addr", 64'(if_mc_addr), 64'd0);
        check("rst_valid", 64'(if_id_valid), 64'd0);
        check("rst_instr", 64'(if_id_instr), 64'd0);
        check("rst_pc", 64'(if_id_pc), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        id_if_ready = 1'b1;

        // Reset asserted in the middle of a wait cycle
        wait_req(1'b0, ok, a);
        if (!ok) fail_now("first_req");
        @(posedge clock);
        #2;
        reset = 1'b0;
        model_restart('0);
        #1;
        check("midwait_rst_mc_en", 64'(if_mc_en), 64'd0);
        check("midwait_rst_valid", 64'(if_id_valid), 64'd0);
        check("midwait_rst_addr", 64'(if_mc_addr), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        wait_req(1'b0, ok, a);
        if (!ok) fail_now("req_after_reset");
        else check("first_fetch_addr", 64'(a), 64'd0);

        // Free run: pc 0,2,4,6 with one instruction every MC_LAT+1 cycles
        prev_at = 0;
        for (int i = 0; i < 4; i++) begin
            wait_valid(ok, pc, ins, at);
            if (!ok) begin
                fail_now("freerun_valid");
                break;
            end
            check("freerun_pc", 64'(pc), 64'(2 * i));
            check("freerun_instr", 64'(ins), 64'(6 * i));
            if (i > 0) check("freerun_spacing", 64'(at - prev_at), 64'(MC_LAT + 1));
            prev_at = at;
        end

        // MEM preempts the wait of pc 4
        do_redirect(18'h4);
        wait_req(1'b0, ok, a);
        if (!ok) fail_now("preempt_req");
        else check("preempt_req_addr", 64'(a), 64'h4);
        @(posedge clock);
        #1;
        mem_mc_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("preempt_mc_en_low", 64'(if_mc_en), 64'd0);
            @(posedge clock);
            #1;
        end
        mem_mc_en = 1'b0;
        wait_req(1'b0, ok, a);
        if (!ok) fail_now("refetch_req");
        else check("refetch_addr", 64'(a), 64'h4);
        for (int i = 0; i < 2; i++) begin
            wait_valid(ok, pc, ins, at);
            if (!ok) fail_now("preempt_valid");
            else check("preempt_order_pc", 64'(pc), 64'(4 + 2 * i));
        end

        // Decode stalls: FIFO fills to depth and fetch stops
        do_redirect(18'h0);
        id_if_ready = 1'b0;
        repeat (11) @(posedge clock);
        @(negedge clock);
        check("full_valid", 64'(if_id_valid), 64'd1);
        check("full_head_pc", 64'(if_id_pc), 64'd0);
        check("full_head_instr", 64'(if_id_instr), 64'd0);
        check("full_mc_en", 64'(if_mc_en), 64'd0);
        @(posedge clock);
        #1;
        id_if_ready = 1'b1;
        prev_at = 0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            wait_valid(ok, pc, ins, at);
            if (!ok) fail_now("drain_valid");
            else begin
                check("drain_pc", 64'(pc), 64'(2 * i));
                if (i > 0) check("drain_back_to_back", 64'(at - prev_at), 64'd1);
                prev_at = at;
            end
        end
        wait_req(1'b0, ok, a);
        if (!ok) fail_now("resume_req");
        else check("resume_addr", 64'(a), 64'h4);

        // Redirect lands on the capture edge; odd target is forced even
        wait_req(1'b1, ok, a);
        if (!ok) fail_now("cap_redirect_req");
        @(posedge clock);
        do_redirect(18'h00101);
        wait_req(1'b0, ok, a);
        if (!ok) fail_now("after_redirect_req");
        else check("redirect_addr_even", 64'(a), 64'h00100);

        // PC wrap at the top of the address space
        do_redirect(18'h3FFFE);
        wait_req(1'b0, ok, a);
        if (!ok) fail_now("top_req");
        else check("top_addr", 64'(a), 64'h3FFFE);
        wait_req(1'b1, ok, a);
        if (!ok) fail_now("wrap_req");
        else check("wrap_addr", 64'(a), 64'h0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            if ($urandom_range(0, 31) == 0) begin
                if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(18'h3FFF0, 18'h3FFFF));
                else a = ADDR_W'($urandom_range(0, 18'h3FFFF));
                redirect_en   = 1'b1;
                redirect_addr = a;
                id_if_ready   = 1'b0;
                mem_mc_en     = ($urandom_range(0, 3) == 0);
                model_restart(a);
            end else begin
                redirect_en = 1'b0;
                mem_mc_en   = ($urandom_range(0, 3) == 0);
                id_if_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clock);
        #1;
        redirect_en = 1'b0;
        mem_mc_en   = 1'b0;
        id_if_ready = 1'b1;
        repeat (40) @(posedge clock);
        @(negedge clock);
        check("progress", 64'(hs_total >= 200), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
